// File: rtl/jtag_dr_shifter.sv
// JTAG user data register: framed {data, addr, wr} shifts into per-channel write strobes and capture-time readback.
// Latency: rd_en/wr_en are registered and go high on the capture/update edge; TDO is sr[0], valid from the capture edge.
// No backpressure: the TAP controller paces every transfer, and wrong-length frames are dropped and flagged in frame_err.
module jtag_dr_shifter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                            bscan_tck,
  input  logic                            rst_n,
  input  logic                            tap_reset,
  input  logic                            bscan_sel,
  input  logic                            tap_capture,
  input  logic                            bscan_shift,
  input  logic                            tap_update,
  input  logic                            bscan_tdi,
  output logic                            bscan_tdo,
  input  logic [(2**ADDR_W)*DATA_W-1:0]   rd_data,
  output logic [ADDR_W-1:0]               rd_addr,
  output logic                            rd_en,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [DATA_W-1:0]               wr_data,
  output logic                            frame_err
);

  localparam int NUM_CH  = 2**ADDR_W;
  localparam int FRAME_W = DATA_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {IDLE, CAPT, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] sr, sr_nxt;
  logic [CNT_W-1:0]   bit_cnt, cnt_nxt;
  logic [ADDR_W-1:0]  ptr, ptr_nxt;
  logic               err, err_nxt;
  logic               rd_en_q, rd_en_nxt;
  logic               wr_en_q, wr_en_nxt;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_nxt;
  logic [DATA_W-1:0]  wr_data_q, wr_data_nxt;
  logic [DATA_W-1:0]  rd_word;
  logic               cap_req;
  logic               shift_req;

  assign cap_req   = tap_capture & bscan_sel;
  assign shift_req = bscan_shift & bscan_sel;

  always_comb begin
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ptr == ADDR_W'(c)) rd_word = rd_data[c*DATA_W +: DATA_W];
    end
  end

  // Priority inside a frame is capture > update > shift; update is deliberately not gated by sel.
  always_comb begin
    state_nxt   = state;
    sr_nxt      = sr;
    cnt_nxt     = bit_cnt;
    ptr_nxt     = ptr;
    err_nxt     = err;
    rd_en_nxt   = 1'b0;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;
    case (state)
      IDLE: begin
        if (cap_req) begin
          sr_nxt    = {rd_word, ptr, err};
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          rd_en_nxt = 1'b1;
          state_nxt = CAPT;
        end
      end
      CAPT, SHIFT: begin
        if (cap_req) begin
          sr_nxt    = {rd_word, ptr, err};
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          rd_en_nxt = 1'b1;
          state_nxt = CAPT;
        end else if (tap_update) begin
          state_nxt = IDLE;
          if (bit_cnt == CNT_FULL) begin
            ptr_nxt = sr[ADDR_W:1];
            if (sr[0]) begin
              wr_en_nxt   = 1'b1;
              wr_addr_nxt = sr[ADDR_W:1];
              wr_data_nxt = sr[FRAME_W-1:ADDR_W+1];
            end
          end else begin
            err_nxt = 1'b1;
          end
        end else if (shift_req) begin
          sr_nxt = {bscan_tdi, sr[FRAME_W-1:1]};
          if (bit_cnt != CNT_SAT) cnt_nxt = bit_cnt + CNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge bscan_tck or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      err       <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (tap_reset) begin
      state     <= IDLE;
      sr        <= '0;
      bit_cnt   <= '0;
      ptr       <= '0;
      err       <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state     <= state_nxt;
      sr        <= sr_nxt;
      bit_cnt   <= cnt_nxt;
      ptr       <= ptr_nxt;
      err       <= err_nxt;
      rd_en_q   <= rd_en_nxt;
      wr_en_q   <= wr_en_nxt;
      wr_addr_q <= wr_addr_nxt;
      wr_data_q <= wr_data_nxt;
    end
  end

  assign bscan_tdo = sr[0];
  assign rd_addr   = ptr;
  assign frame_err = err;
  assign rd_en     = rd_en_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_jtag_dr_shifter.sv
// Bench for jtag_dr_shifter (DATA_W=8, ADDR_W=2): table of frames plus reset/tap_reset/deselect sequences.
module tb_jtag_dr_shifter;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 2;
  localparam int NUM_CH  = 4;
  localparam int FRAME_W = 11;

  logic bscan_tck = 1'b0;
  logic rst_n = 1'b0, tap_reset = 1'b0, bscan_sel = 1'b0;
  logic tap_capture = 1'b0, bscan_shift = 1'b0, tap_update = 1'b0, bscan_tdi = 1'b0;
  logic bscan_tdo, rd_en, wr_en, frame_err;
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;

  jtag_dr_shifter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .bscan_tck(bscan_tck), .rst_n(rst_n), .tap_reset(tap_reset), .bscan_sel(bscan_sel),
    .tap_capture(tap_capture), .bscan_shift(bscan_shift), .tap_update(tap_update),
    .bscan_tdi(bscan_tdi), .bscan_tdo(bscan_tdo), .rd_data(rd_data), .rd_addr(rd_addr),
    .rd_en(rd_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_err(frame_err)
  );

  always #5 bscan_tck = ~bscan_tck;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                nshift;
    logic              exp_wr;
    logic              exp_err;
    logic [ADDR_W-1:0] exp_ptr;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [ADDR_W-1:0] m_ptr = '0;
  logic m_err = 1'b0;
  logic [DATA_W-1:0] ch_val [NUM_CH];
  logic tdo_q [$];
  logic [ADDR_W+DATA_W-1:0] wr_q [$];
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bscan_tck);
    #1;
  endtask

  task automatic sample_tdo(input string name);
    if (tdo_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got tdo=%0b expected no further bit", name, bscan_tdo);
    end else begin
      check(name, 32'(bscan_tdo), 32'(tdo_q.pop_front()));
    end
  endtask

  task automatic run_frame(input vec_t v);
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-1:0] cap;
    logic [ADDR_W+DATA_W-1:0] got;
    frame = {v.data, v.addr, v.wr};
    bscan_sel = 1'b1;
    tap_capture = 1'b1;
    cap = {ch_val[m_ptr], m_ptr, m_err};
    m_err = 1'b0;
    tdo_q.delete();
    for (int i = 0; i < FRAME_W; i++) tdo_q.push_back(cap[i]);
    tick();
    tap_capture = 1'b0;
    check("rd_en_capture", 32'(rd_en), 32'd1);
    check("rd_addr_capture", 32'(rd_addr), 32'(m_ptr));
    sample_tdo("tdo_bit0");
    for (int i = 0; i < v.nshift; i++) begin
      bscan_tdi = (i < FRAME_W) ? frame[i] : 1'($urandom_range(0, 1));
      bscan_shift = 1'b1;
      tdo_q.push_back(bscan_tdi);
      tick();
      bscan_shift = 1'b0;
      if (i == 0) check("rd_en_pulse_end", 32'(rd_en), 32'd0);
      sample_tdo("tdo_shift");
    end
    if (v.nshift == FRAME_W) begin
      m_ptr = v.addr;
      if (v.wr) wr_q.push_back({v.addr, v.data});
    end else begin
      m_err = 1'b1;
    end
    tap_update = 1'b1;
    tick();
    tap_update = 1'b0;
    check("wr_en_update", 32'(wr_en), 32'(v.exp_wr));
    check("frame_err", 32'(frame_err), 32'(v.exp_err));
    check("rd_addr_update", 32'(rd_addr), 32'(v.exp_ptr));
    check("rd_en_update", 32'(rd_en), 32'd0);
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        got = wr_q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(got[ADDR_W+DATA_W-1:DATA_W]));
        check("wr_data", 32'(wr_data), 32'(got[DATA_W-1:0]));
      end
    end
    tick();
    check("wr_en_one_cycle", 32'(wr_en), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    ch_val[0] = 8'h11; ch_val[1] = 8'h22; ch_val[2] = 8'h3C; ch_val[3] = 8'h44;
    for (int c = 0; c < NUM_CH; c++) rd_data[c*DATA_W +: DATA_W] = ch_val[c];

    vecs[0] = '{1'b1, 2'd2, 8'hA5, 11, 1'b1, 1'b0, 2'd2};
    vecs[1] = '{1'b0, 2'd2, 8'h00, 11, 1'b0, 1'b0, 2'd2};
    vecs[2] = '{1'b1, 2'd1, 8'h77,  7, 1'b0, 1'b1, 2'd2};
    vecs[3] = '{1'b0, 2'd2, 8'h00, 11, 1'b0, 1'b0, 2'd2};
    vecs[4] = '{1'b1, 2'd3, 8'hC3, 15, 1'b0, 1'b1, 2'd2};
    vecs[5] = '{1'b1, 2'd0, 8'h00,  0, 1'b0, 1'b1, 2'd2};
    vecs[6] = '{1'b1, 2'd3, 8'h5A, 11, 1'b1, 1'b0, 2'd3};
    vecs[7] = '{1'b0, 2'd1, 8'h00, 11, 1'b0, 1'b0, 2'd1};

    #1;
    check("reset_tdo", 32'(bscan_tdo), 32'd0);
    check("reset_rd_en", 32'(rd_en), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    #20 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Asynchronous reset five bits into a shift, then a clean write.
    bscan_sel = 1'b1;
    tap_capture = 1'b1;
    tick();
    tap_capture = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bscan_tdi = 1'b1;
      bscan_shift = 1'b1;
      tick();
    end
    bscan_shift = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_tdo", 32'(bscan_tdo), 32'd0);
    check("arst_rd_addr", 32'(rd_addr), 32'd0);
    check("arst_wr_addr", 32'(wr_addr), 32'd0);
    check("arst_wr_data", 32'(wr_data), 32'd0);
    check("arst_frame_err", 32'(frame_err), 32'd0);
    check("arst_rd_en", 32'(rd_en), 32'd0);
    #3 rst_n = 1'b1;
    m_ptr = '0;
    m_err = 1'b0;
    wr_q.delete();
    tick();
    run_frame('{1'b1, 2'd2, 8'h96, 11, 1'b1, 1'b0, 2'd2});

    // tap_reset mid-shift must return to IDLE: later shift/update are ignored.
    bscan_sel = 1'b1;
    tap_capture = 1'b1;
    tick();
    tap_capture = 1'b0;
    bscan_tdi = 1'b1;
    bscan_shift = 1'b1;
    tick();
    tick();
    bscan_shift = 1'b0;
    tap_reset = 1'b1;
    tick();
    tap_reset = 1'b0;
    m_ptr = '0;
    check("tapreset_rd_addr", 32'(rd_addr), 32'd0);
    check("tapreset_wr_data", 32'(wr_data), 32'd0);
    check("tapreset_tdo", 32'(bscan_tdo), 32'd0);
    bscan_shift = 1'b1;
    tick();
    tick();
    bscan_shift = 1'b0;
    check("idle_shift_tdo", 32'(bscan_tdo), 32'd0);
    tap_update = 1'b1;
    tick();
    tap_update = 1'b0;
    check("idle_update_err", 32'(frame_err), 32'd0);

    // Deselected TAP traffic from IDLE has no effect.
    bscan_sel = 1'b0;
    bscan_tdi = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tap_capture = (i % 3 == 0);
      bscan_shift = (i % 3 == 1);
      tap_update  = (i % 3 == 2);
      tick();
      check("desel_rd_en", 32'(rd_en), 32'd0);
      check("desel_wr_en", 32'(wr_en), 32'd0);
      check("desel_tdo", 32'(bscan_tdo), 32'd0);
    end
    tap_capture = 1'b0;
    bscan_shift = 1'b0;
    tap_update = 1'b0;
    check("desel_frame_err", 32'(frame_err), 32'd0);
    run_frame('{1'b0, 2'd3, 8'h00, 11, 1'b0, 1'b0, 2'd3});

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
